// File: rtl/div_pkg.sv
// Shared definitions for the divide controller: state encoding, WAIT counter
// width, default multicycle latency and the sign fix-up helper.
package div_pkg;

  localparam int DIV_LATENCY_DEF = 4;
  localparam int CNT_W           = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_FIX,
    ST_DONE
  } div_state_t;

  function automatic logic [31:0] condNeg(input logic [31:0] value, input logic neg);
    return neg ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/result bundle between a divide requester (master) and div_ctrl (slave).
interface div_ctrl_if;

  logic        iStart;
  logic        iSigned;
  logic [31:0] iDividend;
  logic [31:0] iDivisor;
  logic        iFlush;
  logic        oReady;
  logic        oDone;
  logic [31:0] oLO;
  logic [31:0] oHI;
  logic        oDivZero;

  modport master (
    output iStart, iSigned, iDividend, iDivisor, iFlush,
    input  oReady, oDone, oLO, oHI, oDivZero
  );

  modport slave (
    input  iStart, iSigned, iDividend, iDivisor, iFlush,
    output oReady, oDone, oLO, oHI, oDivZero
  );

endinterface

// File: rtl/div_ctrl_div32.sv
// Combinational unsigned 32-bit divider; timing is closed as a multicycle path
// by the WAIT state of div_ctrl.
module DIV32 (
  input  logic [31:0] iQ,
  input  logic [31:0] iD,
  output logic [31:0] oQ,
  output logic [31:0] oR
);

  // A zero divisor is resolved by the controller, so drive a defined value here.
  always_comb begin
    oQ = '0;
    oR = '0;
    if (iD != '0) begin
      oQ = iQ / iD;
      oR = iQ % iD;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Divide controller: sequences operand capture, magnitude setup, a fixed WAIT
// window for DIV32, then sign fix-up into the LO/HI result registers.
module div_ctrl
  import div_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
  input logic       iClk,
  input logic       nRst,
  div_ctrl_if.slave io_bus
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(DIV_LATENCY - 1);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_dividend;
  logic [31:0]      r_divisor;
  logic             r_signed;
  logic             r_sgnA;
  logic             r_sgnB;
  logic [31:0]      r_divQ;
  logic [31:0]      r_divD;
  logic [31:0]      r_lo;
  logic [31:0]      r_hi;
  logic             r_divZero;
  logic             r_done;
  logic             r_ready;

  logic [31:0]      w_q;
  logic [31:0]      w_r;
  logic             w_negA;
  logic             w_negB;

  assign w_negA = r_signed & r_sgnA;
  assign w_negB = r_signed & r_sgnB;

  DIV32 u_div32 (
    .iQ (r_divQ),
    .iD (r_divD),
    .oQ (w_q),
    .oR (w_r)
  );

  assign io_bus.oReady   = r_ready;
  assign io_bus.oDone    = r_done;
  assign io_bus.oLO      = r_lo;
  assign io_bus.oHI      = r_hi;
  assign io_bus.oDivZero = r_divZero;

  // Flush overrides everything and leaves the result registers untouched.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_signed   <= 1'b0;
      r_sgnA     <= 1'b0;
      r_sgnB     <= 1'b0;
      r_divQ     <= '0;
      r_divD     <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_divZero  <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (io_bus.iFlush) begin
        r_state <= ST_IDLE;
        r_ready <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (io_bus.iStart) begin
              r_dividend <= io_bus.iDividend;
              r_divisor  <= io_bus.iDivisor;
              r_signed   <= io_bus.iSigned;
              r_sgnA     <= io_bus.iDividend[31];
              r_sgnB     <= io_bus.iDivisor[31];
              r_state    <= ST_SETUP;
              r_ready    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
            end
          end
          ST_SETUP: begin
            r_divQ  <= condNeg(r_dividend, w_negA);
            r_divD  <= condNeg(r_divisor, w_negB);
            r_cnt   <= '0;
            r_state <= (r_divisor == '0) ? ST_FIX : ST_WAIT;
          end
          ST_WAIT: begin
            if (r_cnt == LAST_WAIT) begin
              r_state <= ST_FIX;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_FIX: begin
            // Quotient sign follows the operand signs; remainder follows the dividend.
            if (r_divD == '0) begin
              r_lo      <= '1;
              r_hi      <= r_dividend;
              r_divZero <= 1'b1;
            end else begin
              r_lo      <= condNeg(w_q, w_negA ^ w_negB);
              r_hi      <= condNeg(w_r, w_negA);
              r_divZero <= 1'b0;
            end
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= ST_DONE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized self-checking bench for div_ctrl; results are predicted with plain
// 64-bit arithmetic and latency from the state sequence timing rules.
module tb_div_ctrl;

  localparam int LAT    = 4;
  localparam int BUDGET = LAT + 12;

  logic        iClk;
  logic        nRst;
  int          vecCount = 0;
  int          errCount = 0;
  logic [31:0] expLo;
  logic [31:0] expHi;
  logic        expZero;

  div_ctrl_if io ();

  div_ctrl #(.DIV_LATENCY(LAT)) dut (
    .iClk   (iClk),
    .nRst   (nRst),
    .io_bus (io.slave)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Truncating division in 64 bits; the 0x80000000 / -1 case falls out naturally.
  function automatic void refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      z = 1'b0;
    end
  endfunction

  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    io.iSigned   = sgn;
    io.iDividend = a;
    io.iDivisor  = b;
    io.iStart    = 1'b1;
    @(posedge iClk);
    #1;
    io.iStart    = 1'b0;
    io.iSigned   = 1'($urandom);
    io.iDividend = $urandom;
    io.iDivisor  = $urandom;
    checkOutput("acceptReady", 32'(io.oReady), 32'd0);
    checkOutput("acceptDone", 32'(io.oDone), 32'd0);
  endtask

  task automatic awaitResult(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit pokeStart);
    int n = 0;
    bit seen = 1'b0;
    refDiv(sgn, a, b, expLo, expHi, expZero);
    while (!seen && n < BUDGET) begin
      @(posedge iClk);
      #1;
      n++;
      if (io.oDone) seen = 1'b1;
      else io.iStart = pokeStart && (n == 2);
    end
    io.iStart = 1'b0;
    checkOutput("doneSeen", 32'(seen), 32'd1);
    checkOutput("latency", 32'(n), (b == 32'd0) ? 32'd2 : 32'(LAT + 2));
    checkOutput("quotient", io.oLO, expLo);
    checkOutput("remainder", io.oHI, expHi);
    checkOutput("divZero", 32'(io.oDivZero), 32'(expZero));
    checkOutput("doneReady", 32'(io.oReady), 32'd1);
  endtask

  task automatic idleCheck();
    @(posedge iClk);
    #1;
    checkOutput("idleDone", 32'(io.oDone), 32'd0);
    checkOutput("idleReady", 32'(io.oReady), 32'd1);
  endtask

  task automatic runOp(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(sgn, a, b);
    awaitResult(sgn, a, b, 1'b0);
    idleCheck();
  endtask

  task automatic countDones(input int cycles, output int dones);
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge iClk);
      #1;
      if (io.oDone) dones++;
    end
  endtask

  initial begin
    int          dones;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] keepLo;
    logic [31:0] keepHi;

    io.iStart    = 1'b0;
    io.iSigned   = 1'b0;
    io.iDividend = '0;
    io.iDivisor  = '0;
    io.iFlush    = 1'b0;
    nRst         = 1'b1;
    #3 nRst = 1'b0;
    #4;
    checkOutput("rstLo", io.oLO, 32'd0);
    checkOutput("rstHi", io.oHI, 32'd0);
    checkOutput("rstDivZero", 32'(io.oDivZero), 32'd0);
    checkOutput("rstDone", 32'(io.oDone), 32'd0);
    checkOutput("rstReady", 32'(io.oReady), 32'd1);

    // First edge after release must already accept a start.
    @(negedge iClk);
    nRst = 1'b1;
    runOp(1'b0, 32'd447, 32'd12);
    checkOutput("u447Lo", io.oLO, 32'd37);
    checkOutput("u447Hi", io.oHI, 32'd3);

    runOp(1'b1, 32'hFFFF_FFF9, 32'd2);
    checkOutput("sNeg7Lo", io.oLO, 32'hFFFF_FFFD);
    checkOutput("sNeg7Hi", io.oHI, 32'hFFFF_FFFF);
    runOp(1'b1, 32'd7, 32'hFFFF_FFFE);
    checkOutput("s7NegLo", io.oLO, 32'hFFFF_FFFD);
    checkOutput("s7NegHi", io.oHI, 32'd1);

    runOp(1'b0, 32'd1, 32'd0);
    checkOutput("u1by0Lo", io.oLO, 32'hFFFF_FFFF);
    checkOutput("u1by0Hi", io.oHI, 32'd1);
    runOp(1'b0, 32'd44, 32'd11);
    checkOutput("u44Lo", io.oLO, 32'd4);

    runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("sMinLo", io.oLO, 32'h8000_0000);
    runOp(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("uMinHi", io.oHI, 32'h8000_0000);

    keepLo = expLo;
    keepHi = expHi;
    applyStimulus(1'b0, 32'd3000, 32'd200);
    @(posedge iClk);
    #1;
    @(posedge iClk);
    #1;
    io.iFlush = 1'b1;
    @(posedge iClk);
    #1;
    io.iFlush = 1'b0;
    checkOutput("flushReady", 32'(io.oReady), 32'd1);
    checkOutput("flushLo", io.oLO, keepLo);
    checkOutput("flushHi", io.oHI, keepHi);
    countDones(LAT + 6, dones);
    checkOutput("flushNoDone", 32'(dones), 32'd0);

    io.iSigned   = 1'b0;
    io.iDividend = 32'd5;
    io.iDivisor  = 32'd1;
    io.iStart    = 1'b1;
    io.iFlush    = 1'b1;
    @(posedge iClk);
    #1;
    io.iStart = 1'b0;
    io.iFlush = 1'b0;
    checkOutput("prioReady", 32'(io.oReady), 32'd1);
    countDones(LAT + 6, dones);
    checkOutput("prioNoDone", 32'(dones), 32'd0);
    checkOutput("prioLo", io.oLO, keepLo);

    applyStimulus(1'b0, 32'd100, 32'd7);
    @(posedge iClk);
    #1;
    @(posedge iClk);
    #1;
    nRst = 1'b0;
    #1;
    checkOutput("midRstLo", io.oLO, 32'd0);
    checkOutput("midRstHi", io.oHI, 32'd0);
    checkOutput("midRstDivZero", 32'(io.oDivZero), 32'd0);
    checkOutput("midRstDone", 32'(io.oDone), 32'd0);
    checkOutput("midRstReady", 32'(io.oReady), 32'd1);
    @(negedge iClk);
    nRst = 1'b1;
    countDones(LAT + 6, dones);
    checkOutput("midRstNoDone", 32'(dones), 32'd0);

    // Second start issued in the DONE cycle, with a stray start during WAIT.
    applyStimulus(1'b0, 32'd20, 32'd6);
    awaitResult(1'b0, 32'd20, 32'd6, 1'b0);
    applyStimulus(1'b0, 32'd8, 32'd3);
    awaitResult(1'b0, 32'd8, 32'd3, 1'b1);
    checkOutput("b2bLo", io.oLO, 32'd2);
    checkOutput("b2bHi", io.oHI, 32'd2);
    idleCheck();

    for (int k = 0; k < 40; k++) begin
      sgn = 1'($urandom);
      a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      applyStimulus(sgn, a, b);
      awaitResult(sgn, a, b, 1'b0);
      if ($urandom_range(0, 2) != 0) idleCheck();
    end
    idleCheck();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter DIV_LATENCY, default 4: number of WAIT cycles granted to the combinational DIV32 multicycle path, legal range 1..15.
REQ-002 SHALL have the port iClk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have the port nRst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have the port iStart, input, 1 bit: divide request, accepted only on a rising edge where oReady=1.
REQ-005 SHALL have the port iSigned, input, 1 bit: 1 selects two's-complement operands, 0 selects unsigned; sampled with iStart.
REQ-006 SHALL have the port iDividend, input, 32 bits: dividend; sampled with iStart.
REQ-007 SHALL have the port iDivisor, input, 32 bits: divisor; sampled with iStart.
REQ-008 SHALL have the port iFlush, input, 1 bit: pipeline flush; aborts any operation in progress.
REQ-009 SHALL have the port oReady, output, 1 bit: high in IDLE and DONE.
REQ-010 SHALL have the port oDone, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have the port oLO, output, 32 bits: quotient register.
REQ-012 SHALL have the port oHI, output, 32 bits: remainder register.
REQ-013 SHALL have the port oDivZero, output, 1 bit: registered; set when the last completed operation had divisor 0.

Function
REQ-014 SHALL implement the states IDLE, SETUP, WAIT, FIX and DONE.
REQ-015 IDLE or DONE, iStart=1, iFlush=0: SHALL capture the operands, iSigned and the sign bits, then go to SETUP.
REQ-016 IDLE or DONE, no accepted start: SHALL go to IDLE.
REQ-017 SETUP: SHALL register the divider inputs, taking magnitudes when iSigned=1 and raw values otherwise; SHALL clear the WAIT counter.
REQ-018 SETUP: if the divisor is 0, SHALL go to FIX; otherwise SHALL go to WAIT.
REQ-019 WAIT: SHALL stay exactly DIV_LATENCY cycles, then go to FIX; the divider inputs SHALL stay stable throughout.
REQ-020 FIX: SHALL load oLO and oHI, and update oDivZero, then go to DONE.
REQ-021 DONE: oDone=1 for exactly this cycle; oLO, oHI and oDivZero SHALL hold until the next FIX.
REQ-022 Latency: start accepted at edge T gives oDone=1 in cycle T+3+DIV_LATENCY; for divisor 0, oDone=1 in cycle T+3.
REQ-023 Signed results SHALL truncate toward zero: quotient negated if dividend sign XOR divisor sign; remainder negated if dividend sign.
REQ-024 Divide by zero (both modes): oLO=32'hFFFFFFFF, oHI=dividend, oDivZero=1.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF: oLO=0x80000000, oHI=0, oDivZero=0, with no special-case logic.
REQ-026 iFlush=1 in any state: next state SHALL be IDLE, no oDone, and oLO/oHI/oDivZero unchanged.
REQ-027 iFlush has priority over a simultaneous iStart.
REQ-028 iStart in SETUP, WAIT or FIX: SHALL be ignored, not queued.
REQ-029 Back-to-back operation: a start accepted in DONE SHALL go directly to SETUP with no idle cycle.

Reset
REQ-030 nRst=0: state=IDLE immediately (asynchronous); oLO=0, oHI=0, oDivZero=0, oDone=0, oReady=1, counter=0, captured operands=0.
REQ-031 Reset asserted mid-operation: SHALL abort; oDone SHALL NOT assert after release.
REQ-032 Release of reset: the first start SHALL be accepted on the first rising edge with nRst=1.

Structure
REQ-033 State encodings and the DIV_LATENCY default SHALL live in a shared package, div_pkg.
REQ-034 SHALL instantiate exactly one sub-module, DIV32 (combinational unsigned 32-bit: iQ, iD -> oQ, oR), fed only from the SETUP registers.
REQ-035 Sign fix-up and the zero check SHALL be local logic in div_ctrl.

Verification
REQ-036 Unsigned 447/12, DIV_LATENCY=4, start at T -> oDone only at T+7, oLO=37, oHI=3, oDivZero=0.
REQ-037 Signed -7/2 -> oLO=0xFFFFFFFD, oHI=0xFFFFFFFF; then signed 7/-2 -> oLO=0xFFFFFFFD, oHI=1.
REQ-038 Unsigned 1/0 -> oDone at T+3, oLO=0xFFFFFFFF, oHI=1, oDivZero=1; then 44/11 -> oLO=4, oHI=0, oDivZero=0.
REQ-039 Signed 0x80000000/0xFFFFFFFF -> oLO=0x80000000, oHI=0; unsigned same operands -> oLO=0, oHI=0x80000000.
REQ-040 3000/200 with iFlush=1 at T+3 -> no oDone, oLO/oHI keep the prior result, oReady=1 at T+4; nRst low during WAIT -> outputs 0 at once, no oDone after release.
REQ-041 8/3 started in the DONE cycle of a prior op -> SETUP next cycle, oDone exactly DIV_LATENCY+3 later, oLO=2, oHI=2; iStart during WAIT ignored.
